// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, functs, ALU op and access size
// encodings, and the control bundle carried into the ID/EX register.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [5:0] {
    ALU_NOP  = 6'd0,
    ALU_ADD  = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_AND  = 6'd3,
    ALU_OR   = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_NOR  = 6'd6,
    ALU_SLT  = 6'd7,
    ALU_SLTU = 6'd8,
    ALU_SLL  = 6'd9,
    ALU_SRL  = 6'd10,
    ALU_SRA  = 6'd11,
    ALU_SLLV = 6'd12,
    ALU_SRLV = 6'd13,
    ALU_SRAV = 6'd14,
    ALU_LUI  = 6'd15,
    ALU_ANDI = 6'd16,
    ALU_ORI  = 6'd17,
    ALU_XORI = 6'd18,
    ALU_BEQ  = 6'd19,
    ALU_BNE  = 6'd20
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    reg_dst;
    logic    alu_src;
    logic    jr;
    logic    jal;
    alu_op_e alu_op;
    size_e   size;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic alu_op_e funct_alu(input logic [5:0] fn);
    alu_op_e op;
    op = ALU_NOP;
    unique case (fn)
      F_SLL:         op = ALU_SLL;
      F_SRL:         op = ALU_SRL;
      F_SRA:         op = ALU_SRA;
      F_SLLV:        op = ALU_SLLV;
      F_SRLV:        op = ALU_SRLV;
      F_SRAV:        op = ALU_SRAV;
      F_ADD, F_ADDU: op = ALU_ADD;
      F_SUB, F_SUBU: op = ALU_SUB;
      F_AND:         op = ALU_AND;
      F_OR:          op = ALU_OR;
      F_XOR:         op = ALU_XOR;
      F_NOR:         op = ALU_NOR;
      F_SLT:         op = ALU_SLT;
      F_SLTU:        op = ALU_SLTU;
      default:       op = ALU_NOP;
    endcase
    return op;
  endfunction

  function automatic size_e mem_size(input logic [5:0] op);
    size_e sz;
    sz = SZ_WORD;
    unique case (op)
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file, zero register, async clear and an
// optional write-to-read bypass so WB data is visible in the same cycle.
module regfile_bypass #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr;
  logic              w_byp1;
  logic              w_byp2;

  assign w_wr   = i_we && (i_waddr != '0);
  assign w_byp1 = (BYPASS_EN != 0) && w_wr && (i_waddr == i_raddr1);
  assign w_byp2 = (BYPASS_EN != 0) && w_wr && (i_waddr == i_raddr2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = r_mem[i_raddr1];
    if (i_raddr1 == '0) begin
      o_rdata1 = '0;
    end else if (w_byp1) begin
      o_rdata1 = i_wdata;
    end
  end

  always_comb begin
    o_rdata2 = r_mem[i_raddr2];
    if (i_raddr2 == '0) begin
      o_rdata2 = '0;
    end else if (w_byp2) begin
      o_rdata2 = i_wdata;
    end
  end

endmodule

// File: rtl/stage_id_pipe.sv
// Decode stage with register read, load-use stall, flush handling and
// the ID/EX pipeline register feeding EX.
module stage_id_pipe
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int HAZARD_EN = 1,
  parameter int BYPASS_EN = 1
) (
  input  logic              Clk_in,
  input  logic              Rst_n_in,
  input  logic              Valid_in,
  input  logic [31:0]       Instruction_in,
  input  logic [PC_W-1:0]   PCAddResult_in,
  input  logic              Flush_in,
  input  logic              RegWrite_wb_in,
  input  logic [REG_AW-1:0] WriteReg_wb_in,
  input  logic [DATA_W-1:0] WriteData_wb_in,
  output logic              Stall_out,
  output logic              Valid_ex,
  output logic              RegWrite_ex,
  output logic              MemtoReg_ex,
  output logic              Branch_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              RegDst_ex,
  output logic              ALUSrc_ex,
  output logic              JR_ex,
  output logic              JAL_ex,
  output logic [5:0]        ALUOp_ex,
  output logic [1:0]        Size_ex,
  output logic [PC_W-1:0]   PCAddResult_ex,
  output logic [DATA_W-1:0] ReadData1_ex,
  output logic [DATA_W-1:0] ReadData2_ex,
  output logic [DATA_W-1:0] SignExt_ex,
  output logic [REG_AW-1:0] Rs_ex,
  output logic [REG_AW-1:0] Rt_ex,
  output logic [REG_AW-1:0] Rd_ex
);

  logic [5:0]        w_op;
  logic [5:0]        w_fn;
  logic [15:0]       w_imm;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_sext;
  ctrl_t             w_ctrl;
  logic              w_hz;
  logic              w_issue;

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_sext;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;

  assign w_op   = Instruction_in[31:26];
  assign w_fn   = Instruction_in[5:0];
  assign w_imm  = Instruction_in[15:0];
  assign w_rs   = REG_AW'(Instruction_in[25:21]);
  assign w_rt   = REG_AW'(Instruction_in[20:16]);
  assign w_rd   = REG_AW'(Instruction_in[15:11]);
  assign w_sext = {{(DATA_W-16){w_imm[15]}}, w_imm};

  regfile_bypass #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .REG_AW    (REG_AW),
    .BYPASS_EN (BYPASS_EN)
  ) u_rf (
    .i_clk    (Clk_in),
    .i_rst_n  (Rst_n_in),
    .i_we     (RegWrite_wb_in),
    .i_waddr  (WriteReg_wb_in),
    .i_wdata  (WriteData_wb_in),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  always_comb begin
    w_ctrl = CTRL_NOP;
    unique case (w_op)
      OP_RTYPE: begin
        if (w_fn == F_JR) begin
          w_ctrl.jr = 1'b1;
        end else begin
          w_ctrl.alu_op    = funct_alu(w_fn);
          w_ctrl.reg_write = (w_ctrl.alu_op != ALU_NOP);
          w_ctrl.reg_dst   = 1'b1;
        end
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.size       = mem_size(w_op);
      end
      OP_SW, OP_SH, OP_SB: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.size      = mem_size(w_op);
      end
      OP_BEQ, OP_BNE: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = (w_op == OP_BEQ) ? ALU_BEQ : ALU_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        unique case (w_op)
          OP_SLTI:  w_ctrl.alu_op = ALU_SLT;
          OP_SLTIU: w_ctrl.alu_op = ALU_SLTU;
          OP_ANDI:  w_ctrl.alu_op = ALU_ANDI;
          OP_ORI:   w_ctrl.alu_op = ALU_ORI;
          OP_XORI:  w_ctrl.alu_op = ALU_XORI;
          OP_LUI:   w_ctrl.alu_op = ALU_LUI;
          default:  w_ctrl.alu_op = ALU_ADD;
        endcase
      end
      // Link target and r31 are resolved by WB; EX only needs the flag.
      OP_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jal       = 1'b1;
      end
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  // rt compare is unconditional: cheaper than qualifying by format.
  always_comb begin
    w_hz = (HAZARD_EN != 0) && r_valid && r_ctrl.mem_read &&
           (r_rt != '0) && Valid_in &&
           ((r_rt == w_rs) || (r_rt == w_rt));
  end

  assign Stall_out = w_hz && !Flush_in;
  assign w_issue   = Valid_in && !Flush_in && !w_hz;

  always_ff @(posedge Clk_in or negedge Rst_n_in) begin
    if (!Rst_n_in) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_sext  <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else begin
      r_valid <= w_issue;
      r_ctrl  <= w_issue ? w_ctrl : CTRL_NOP;
      r_pc    <= PCAddResult_in;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
      r_sext  <= w_sext;
      r_rs    <= w_rs;
      r_rt    <= w_rt;
      r_rd    <= w_rd;
    end
  end

  assign Valid_ex       = r_valid;
  assign RegWrite_ex    = r_ctrl.reg_write;
  assign MemtoReg_ex    = r_ctrl.mem_to_reg;
  assign Branch_ex      = r_ctrl.branch;
  assign MemRead_ex     = r_ctrl.mem_read;
  assign MemWrite_ex    = r_ctrl.mem_write;
  assign RegDst_ex      = r_ctrl.reg_dst;
  assign ALUSrc_ex      = r_ctrl.alu_src;
  assign JR_ex          = r_ctrl.jr;
  assign JAL_ex         = r_ctrl.jal;
  assign ALUOp_ex       = r_ctrl.alu_op;
  assign Size_ex        = r_ctrl.size;
  assign PCAddResult_ex = r_pc;
  assign ReadData1_ex   = r_rd1;
  assign ReadData2_ex   = r_rd2;
  assign SignExt_ex     = r_sext;
  assign Rs_ex          = r_rs;
  assign Rt_ex          = r_rt;
  assign Rd_ex          = r_rd;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed checks of stage_id_pipe: default build plus a 64-bit build
// with the register-file bypass turned off, both fed the same stimulus.
module tb_stage_id_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_idx;
  logic [31:0] wb_d;
  logic [63:0] wb_d64;

  logic        a_stall, a_valid, a_rw, a_m2r, a_br, a_mr, a_mw;
  logic        a_rdst, a_asrc, a_jr, a_jal;
  logic [5:0]  a_aop;
  logic [1:0]  a_sz;
  logic [31:0] a_pc, a_rd1, a_rd2, a_sext;
  logic [4:0]  a_rs, a_rt, a_rd;

  logic        b_stall, b_valid, b_rw, b_m2r, b_br, b_mr, b_mw;
  logic        b_rdst, b_asrc, b_jr, b_jal;
  logic [5:0]  b_aop;
  logic [1:0]  b_sz;
  logic [31:0] b_pc;
  logic [63:0] b_rd1, b_rd2, b_sext;
  logic [4:0]  b_rs, b_rt, b_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign wb_d64 = {32'h0, wb_d};

  stage_id_pipe u_dut (
    .Clk_in (clk), .Rst_n_in (rst_n), .Valid_in (valid),
    .Instruction_in (instr), .PCAddResult_in (pc), .Flush_in (flush),
    .RegWrite_wb_in (wb_we), .WriteReg_wb_in (wb_idx),
    .WriteData_wb_in (wb_d), .Stall_out (a_stall), .Valid_ex (a_valid),
    .RegWrite_ex (a_rw), .MemtoReg_ex (a_m2r), .Branch_ex (a_br),
    .MemRead_ex (a_mr), .MemWrite_ex (a_mw), .RegDst_ex (a_rdst),
    .ALUSrc_ex (a_asrc), .JR_ex (a_jr), .JAL_ex (a_jal),
    .ALUOp_ex (a_aop), .Size_ex (a_sz), .PCAddResult_ex (a_pc),
    .ReadData1_ex (a_rd1), .ReadData2_ex (a_rd2), .SignExt_ex (a_sext),
    .Rs_ex (a_rs), .Rt_ex (a_rt), .Rd_ex (a_rd)
  );

  stage_id_pipe #(.DATA_W (64), .BYPASS_EN (0)) u_dut64 (
    .Clk_in (clk), .Rst_n_in (rst_n), .Valid_in (valid),
    .Instruction_in (instr), .PCAddResult_in (pc), .Flush_in (flush),
    .RegWrite_wb_in (wb_we), .WriteReg_wb_in (wb_idx),
    .WriteData_wb_in (wb_d64), .Stall_out (b_stall), .Valid_ex (b_valid),
    .RegWrite_ex (b_rw), .MemtoReg_ex (b_m2r), .Branch_ex (b_br),
    .MemRead_ex (b_mr), .MemWrite_ex (b_mw), .RegDst_ex (b_rdst),
    .ALUSrc_ex (b_asrc), .JR_ex (b_jr), .JAL_ex (b_jal),
    .ALUOp_ex (b_aop), .Size_ex (b_sz), .PCAddResult_ex (b_pc),
    .ReadData1_ex (b_rd1), .ReadData2_ex (b_rd2), .SignExt_ex (b_sext),
    .Rs_ex (b_rs), .Rt_ex (b_rt), .Rd_ex (b_rd)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] idx,
                    input logic [31:0] d);
    wb_we  = we;
    wb_idx = idx;
    wb_d   = d;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    instr = 32'h0;
    pc    = 32'h0;
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    #2;
    check("rst_valid", a_valid, 0);
    check("rst_regwrite", a_rw, 0);
    check("rst_stall", a_stall, 0);
    check("rst_rd1", a_rd1, 0);
    tick();
    rst_n = 1'b1;

    wb(1'b1, 5'd4, 32'h100);
    tick();
    wb(1'b1, 5'd1, 32'h7);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    valid = 1'b1;
    instr = r_ins(5'd4, 5'd1, 5'd6, 6'h20);
    pc    = 32'h1004;
    tick();
    check("add_rd1", a_rd1, 32'h100);
    check("add_rd2", a_rd2, 32'h7);
    check("add_valid", a_valid, 1);
    check("add_regwrite", a_rw, 1);
    check("add_regdst", a_rdst, 1);
    check("add_aluop", a_aop, 6'd1);
    check("add_rd", a_rd, 5'd6);
    check("add_pc", a_pc, 32'h1004);

    rst_n = 1'b0;
    wb(1'b1, 5'd3, 32'h55);
    #1;
    check("mrst_valid", a_valid, 0);
    check("mrst_rd1", a_rd1, 0);
    check("mrst_pc", a_pc, 0);
    check("mrst_regwrite", a_rw, 0);
    check("mrst_stall", a_stall, 0);
    tick();
    rst_n = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    instr = r_ins(5'd4, 5'd3, 5'd6, 6'h20);
    tick();
    check("mrst_r4_clear", a_rd1, 0);
    check("mrst_r3_nowrite", a_rd2, 0);
    check("mrst_issue", a_valid, 1);

    wb(1'b1, 5'd5, 32'h1234);
    instr = r_ins(5'd5, 5'd0, 5'd6, 6'h20);
    tick();
    check("byp_on", a_rd1, 32'h1234);
    check("byp_off", b_rd1, 0);
    check("byp_rs", a_rs, 5'd5);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("byp_off_stored", b_rd1, 64'h1234);

    instr = i_ins(6'h23, 5'd4, 5'd8, 16'h0);
    tick();
    check("lw_memread", a_mr, 1);
    check("lw_memtoreg", a_m2r, 1);
    check("lw_alusrc", a_asrc, 1);
    check("lw_size", a_sz, 2'b00);
    check("lw_rt", a_rt, 5'd8);
    instr = r_ins(5'd8, 5'd1, 5'd9, 6'h20);
    #1;
    check("lu_stall", a_stall, 1);
    check("lu_stall64", b_stall, 1);
    tick();
    check("lu_bubble_valid", a_valid, 0);
    check("lu_bubble_rw", a_rw, 0);
    check("lu_bubble_mr", a_mr, 0);
    check("lu_stall_clear", a_stall, 0);
    tick();
    check("lu_issue_valid", a_valid, 1);
    check("lu_issue_rw", a_rw, 1);
    check("lu_issue_rd", a_rd, 5'd9);

    instr = i_ins(6'h23, 5'd4, 5'd0, 16'h0);
    tick();
    instr = r_ins(5'd0, 5'd1, 5'd9, 6'h20);
    #1;
    check("lu_r0_nostall", a_stall, 0);
    tick();
    check("lu_r0_issue", a_valid, 1);

    instr = i_ins(6'h23, 5'd4, 5'd8, 16'h0);
    tick();
    instr = r_ins(5'd8, 5'd1, 5'd9, 6'h20);
    flush = 1'b1;
    #1;
    check("fl_stall", a_stall, 0);
    tick();
    check("fl_bubble_valid", a_valid, 0);
    check("fl_bubble_rw", a_rw, 0);
    flush = 1'b0;

    instr = i_ins(6'h23, 5'd4, 5'd8, 16'h0);
    tick();
    instr = r_ins(5'd1, 5'd8, 5'd9, 6'h20);
    #1;
    check("lu_rt_stall", a_stall, 1);
    tick();
    check("lu_rt_bubble", a_valid, 0);
    tick();
    check("lu_rt_issue", a_valid, 1);

    valid = 1'b0;
    wb(1'b1, 5'd31, 32'h0040_0010);
    tick();
    check("novalid_bubble", a_valid, 0);
    valid = 1'b1;
    wb(1'b1, 5'd0, 32'hDEAD);
    instr = r_ins(5'd31, 5'd0, 5'd2, 6'h20);
    tick();
    check("jal_r31", a_rd1, 32'h0040_0010);
    check("r0_byp_zero", a_rd2, 0);
    wb(1'b0, 5'd0, 32'h0);
    instr = r_ins(5'd0, 5'd31, 5'd2, 6'h20);
    tick();
    check("r0_zero", a_rd1, 0);
    check("r31_rt", b_rd2, 64'h0040_0010);

    instr = {6'h03, 26'h0100004};
    tick();
    check("jal_flag", a_jal, 1);
    check("jal_rw", a_rw, 1);

    instr = i_ins(6'h08, 5'd0, 5'd3, 16'h8001);
    tick();
    check("sext32", a_sext, 32'hFFFF_8001);
    check("sext64", b_sext, 64'hFFFF_FFFF_FFFF_8001);
    check("addi_alusrc", a_asrc, 1);
    instr = i_ins(6'h08, 5'd0, 5'd3, 16'h7FFF);
    tick();
    check("sext32_pos", a_sext, 32'h7FFF);
    check("sext64_pos", b_sext, 64'h7FFF);

    instr = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
    tick();
    check("jr_flag", a_jr, 1);
    check("jr_rw", a_rw, 0);

    instr = i_ins(6'h28, 5'd1, 5'd2, 16'h4);
    tick();
    check("sb_memwrite", a_mw, 1);
    check("sb_size", a_sz, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
